aes_rx_block_fifo: RTL and testbench
====================================

// Module: aes_rx_block_fifo
// PURPOSE
//  Memory-mapped multi-block receive queue between the 8-lane SPI slave and the PicoRV32 bus.
//  It is the next-generation SPI RX buffer: it queues DEPTH received ciphertext blocks of
//  BLOCK_BITS bits instead of holding one. It adds a programmable IRQ threshold, explicit pop,
//  flush, a sticky overflow flag and a drop counter.
//  Sits at the 0x3000_0000 window of the AES SoC device, in parallel with the RAM controller.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  byte base of 64-byte register window
//  BLOCK_BITS  128            block width; multiple of 32, 32..256
//  DEPTH       4              queue entries; power of 2, 2..64
// PORTS
//  clk           in   1           system clock
//  reset         in   1           asynchronous, active-high reset
//  mem_valid     in   1           bus request (already qualified by window select)
//  mem_ready     out  1           one-cycle completion pulse
//  mem_addr      in   32          byte address
//  mem_wdata     in   32          write data
//  mem_wstrb     in   4           write strobes; 0 = read
//  mem_rdata     out  32          read data, valid while mem_ready=1
//  spi_rx_data   in   BLOCK_BITS  block from SPI slave
//  spi_rx_valid  in   1           one-cycle push strobe
//  irq_rx        out  1           level interrupt
//  fifo_level    out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: queue empty, level=0, overflow=0, dropcnt=0, irq_en=0, thresh=1, mem_ready=0, mem_rdata=0, irq_rx=0.
//  Bus handshake:
//  - mem_ready pulses exactly one cycle after mem_valid is seen with mem_ready low (1 wait state).
//  - Side effects occur in the mem_ready cycle; a held mem_valid is not re-executed that cycle.
//  Register map (offset from BASE_ADDR):
//  - 0x00+4k DATAk (RO): word k of head block, k < BLOCK_BITS/32; word0 = bits[31:0].
//    Reads 0 when empty; reads are non-destructive.
//  - 0x20 STATUS (RO): [0]=not_empty, [1]=full, [2]=overflow, [22:16]=level.
//  - 0x24 CTRL: [0]=irq_en (RW); [1]=flush (W1, self-clearing, reads 0); [2]=overflow clear (W1C).
//  - 0x28 POP (WO, any data): removes head block; ignored when empty. No underflow flag.
//  - 0x2C THRESH (RW, [6:0]): IRQ threshold; values 0 and >DEPTH saturate to 1 and DEPTH.
//  - 0x30 DROPCNT (RO, [15:0]): saturating count of discarded blocks; cleared by overflow-clear.
//  - Unmapped offsets in the window read 0; writes to them are ignored; mem_ready still pulses.
//  Push:
//  - spi_rx_valid in cycle N writes the tail; level, STATUS and irq_rx reflect it at N+1.
//  - Push when full with no same-cycle pop: block discarded, overflow<=1, dropcnt++ (saturating).
//  Simultaneous events:
//  - Push + pop while full: both succeed; level unchanged; no overflow.
//  - Push + pop while empty: pop ignored, push lands; level=1.
//  - Flush + push same cycle: flush wins; incoming block silently discarded; overflow and dropcnt unchanged.
//  Pointers: rd/wr pointers wrap modulo DEPTH; level counter is separate, 0..DEPTH.
//  irq_rx: registered, = irq_en && level >= thresh_eff. Deasserts the cycle after a pop or flush brings level below it.
//  Reset mid-transfer: queue contents are discarded; any pending bus access gets no ready pulse.
// STRUCTURE
//  Shared package aes_soc_pkg: register offsets, STATUS/CTRL bit indices, DROPCNT width.
//  Sub-module sync_block_fifo: storage array, pointers, level, full/empty, push/pop/flush.
//  Top level holds bus decode, CTRL/THRESH/overflow/dropcnt, IRQ logic.
//  Storage array is not reset; only pointers and level are reset.
// TESTING
//  1. Push 3 blocks (B0=0x00112233_44556677_8899AABB_CCDDEEFF, ...) -> STATUS level=3,
//     DATA0..3 read B0 words LSW first, then POP and DATA0 shows B1[31:0].
//  2. Push 6 blocks into DEPTH=4 -> level=4, full=1, overflow=1, DROPCNT=2;
//     write CTRL[2] -> overflow=0, DROPCNT=0.
//  3. THRESH=2, irq_en=1: 1 push -> irq_rx=0; 2nd push -> irq_rx=1 next cycle; POP -> irq_rx=0.
//  4. Full queue, spi_rx_valid coincident with POP ready cycle -> level stays 4,
//     overflow=0, new block at tail.
//  5. Flush coincident with push at level=2 -> level=0, overflow=0, DROPCNT=0, DATA0 reads 0.
//  6. Assert reset mid-read and with level=3 -> all outputs 0, level=0, no mem_ready pulse.
//     Read 0x3C -> 0 with a one-cycle mem_ready.

Source files
------------

// File: rtl/aes_rx_block_fifo_pkg.sv
// Shared constants and helpers for the SPI receive block queue: register offsets,
// STATUS/CTRL bit positions, counter widths, register decode and threshold saturation.
package aes_rx_block_fifo_pkg;

   // Register offsets within the 64-byte window
   localparam logic [5:0] OFF_DATA0   = 6'h00;
   localparam logic [5:0] OFF_STATUS  = 6'h20;
   localparam logic [5:0] OFF_CTRL    = 6'h24;
   localparam logic [5:0] OFF_POP     = 6'h28;
   localparam logic [5:0] OFF_THRESH  = 6'h2C;
   localparam logic [5:0] OFF_DROPCNT = 6'h30;

   // STATUS fields
   localparam int unsigned STATUS_NOT_EMPTY = 0;
   localparam int unsigned STATUS_FULL      = 1;
   localparam int unsigned STATUS_OVERFLOW  = 2;
   localparam int unsigned STATUS_LEVEL_LSB = 16;
   localparam int unsigned STATUS_LEVEL_W   = 7;

   // CTRL fields
   localparam int unsigned CTRL_IRQ_EN  = 0;
   localparam int unsigned CTRL_FLUSH   = 1;
   localparam int unsigned CTRL_OVF_CLR = 2;

   localparam int unsigned THRESH_W  = 7;
   localparam int unsigned DROPCNT_W = 16;

   typedef enum logic [2:0] {
      RegData,
      RegStatus,
      RegCtrl,
      RegPop,
      RegThresh,
      RegDropcnt,
      RegNone
   } reg_sel_e;

   // Map a byte address to a register; outside the window or unaligned gives RegNone
   function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned words);
      reg_sel_e sel;
      sel = RegNone;
      if (addr[31:6] == base[31:6] && addr[1:0] == 2'b00) begin
         if (addr[5] == 1'b0) begin
            if ({29'd0, addr[4:2]} < words) sel = RegData;
         end else begin
            case (addr[5:0])
               OFF_STATUS:  sel = RegStatus;
               OFF_CTRL:    sel = RegCtrl;
               OFF_POP:     sel = RegPop;
               OFF_THRESH:  sel = RegThresh;
               OFF_DROPCNT: sel = RegDropcnt;
               default:     sel = RegNone;
            endcase
         end
      end
      return sel;
   endfunction

   // 0 behaves as 1, anything above the queue depth behaves as the depth
   function automatic logic [THRESH_W-1:0] thresh_sat(input logic [THRESH_W-1:0] raw,
                                                      input int unsigned depth);
      if (raw == '0) return THRESH_W'(1);
      if (32'(raw) > depth) return THRESH_W'(depth);
      return raw;
   endfunction

endpackage

// File: rtl/aes_rx_block_fifo_if.sv
// PicoRV32-style memory bus seen by the receive queue.
interface aes_rx_block_fifo_if;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/aes_rx_block_fifo_sync_fifo.sv
// Block storage queue: unreset storage array, wrapping pointers and a separate level counter.
// Flush has priority over push and pop; pop is ignored when empty; a push while full only
// lands if a pop frees a slot in the same cycle.
module aes_rx_block_fifo_sync_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     level_next,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == FULL_LVL);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   // Next-state pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_d = level_q + 1'b1;
         else if (!do_push && do_pop) level_d = level_q - 1'b1;
      end
   end

   // Pointer and level registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write; contents are meaningless until pushed so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign head_data  = mem[rd_ptr_q];
   assign level      = level_q;
   assign level_next = level_d;

endmodule

// File: rtl/aes_rx_block_fifo.sv
// Memory-mapped multi-block SPI receive queue: bus decode with one wait state, control and
// threshold registers, sticky overflow with saturating drop counter, and the level interrupt.
module aes_rx_block_fifo
   import aes_rx_block_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int unsigned BLOCK_BITS = 128,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   aes_rx_block_fifo_if.slave        bus,
   input  logic [BLOCK_BITS-1:0]     spi_rx_data,
   input  logic                      spi_rx_valid,
   output logic                      irq_rx,
   output logic [$clog2(DEPTH):0]    fifo_level
);

   localparam int unsigned WORDS = BLOCK_BITS / 32;
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   // Bus request state
   logic        ready_q;
   logic [31:0] rdata_q;
   reg_sel_e    req_sel_q;
   logic        req_wr_q;
   logic [31:0] req_wdata_q;

   // Control and status state
   logic                 irq_en_q, irq_en_d;
   logic [THRESH_W-1:0]  thresh_q, thresh_d;
   logic                 overflow_q, overflow_d;
   logic [DROPCNT_W-1:0] dropcnt_q, dropcnt_d;
   logic                 irq_q, irq_d;

   // Queue interface
   logic [BLOCK_BITS-1:0] head_data;
   logic [LVL_W-1:0]      level, level_next;
   logic                  full, empty;

   reg_sel_e    sel;
   logic        start;
   logic [31:0] read_val;
   logic [255:0] head_ext;
   logic        wr_go, flush, ovf_clr, pop, drop;
   logic        unused_wdata;

   assign sel      = decode_reg(bus.mem_addr, BASE_ADDR, WORDS);
   assign start    = bus.mem_valid && !ready_q;
   assign head_ext = 256'(head_data);

   // Read mux, sampled when the request is accepted
   always_comb begin
      read_val = '0;
      case (sel)
         RegData: begin
            if (!empty) read_val = head_ext[{bus.mem_addr[4:2], 5'd0} +: 32];
         end
         RegStatus: begin
            read_val[STATUS_NOT_EMPTY] = !empty;
            read_val[STATUS_FULL]      = full;
            read_val[STATUS_OVERFLOW]  = overflow_q;
            read_val[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = STATUS_LEVEL_W'(level);
         end
         RegCtrl:    read_val[CTRL_IRQ_EN] = irq_en_q;
         RegThresh:  read_val[THRESH_W-1:0] = thresh_q;
         RegDropcnt: read_val[DROPCNT_W-1:0] = dropcnt_q;
         default:    read_val = '0;
      endcase
   end

   // Accept a request, hold its decode for the ready cycle and return read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         req_sel_q   <= RegNone;
         req_wr_q    <= 1'b0;
         req_wdata_q <= '0;
      end else begin
         ready_q <= start;
         rdata_q <= '0;
         if (start) begin
            req_sel_q   <= sel;
            req_wr_q    <= |bus.mem_wstrb;
            req_wdata_q <= bus.mem_wdata;
            rdata_q     <= (|bus.mem_wstrb) ? '0 : read_val;
         end
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;

   // Write side effects happen in the ready cycle
   assign wr_go   = ready_q && req_wr_q;
   assign flush   = wr_go && req_sel_q == RegCtrl && req_wdata_q[CTRL_FLUSH];
   assign ovf_clr = wr_go && req_sel_q == RegCtrl && req_wdata_q[CTRL_OVF_CLR];
   assign pop     = wr_go && req_sel_q == RegPop;
   // A pop while full always frees a slot, so only an unpaired push is lost
   assign drop    = spi_rx_valid && !flush && full && !pop;

   assign unused_wdata = ^req_wdata_q[31:THRESH_W];

   // Next-state control registers, drop accounting and interrupt level
   always_comb begin
      irq_en_d   = irq_en_q;
      thresh_d   = thresh_q;
      overflow_d = ovf_clr ? 1'b0 : overflow_q;
      dropcnt_d  = ovf_clr ? '0 : dropcnt_q;
      if (wr_go && req_sel_q == RegCtrl)   irq_en_d = req_wdata_q[CTRL_IRQ_EN];
      if (wr_go && req_sel_q == RegThresh) thresh_d = req_wdata_q[THRESH_W-1:0];
      if (drop) begin
         overflow_d = 1'b1;
         if (dropcnt_d != '1) dropcnt_d = dropcnt_d + 1'b1;
      end
      // Computed from next-state so irq_rx tracks the level in the same cycle
      irq_d = irq_en_d && (8'(level_next) >= 8'(thresh_sat(thresh_d, DEPTH)));
   end

   // Control and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q   <= 1'b0;
         thresh_q   <= THRESH_W'(1);
         overflow_q <= 1'b0;
         dropcnt_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_en_q   <= irq_en_d;
         thresh_q   <= thresh_d;
         overflow_q <= overflow_d;
         dropcnt_q  <= dropcnt_d;
         irq_q      <= irq_d;
      end
   end

   aes_rx_block_fifo_sync_fifo #(
      .WIDTH (BLOCK_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (spi_rx_valid),
      .push_data  (spi_rx_data),
      .pop        (pop),
      .flush      (flush),
      .head_data  (head_data),
      .level      (level),
      .level_next (level_next),
      .full       (full),
      .empty      (empty)
   );

   assign irq_rx     = irq_q;
   assign fifo_level = level;

endmodule

// File: tb/tb_aes_rx_block_fifo.sv
// Self-checking bench for aes_rx_block_fifo: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model.
module tb_aes_rx_block_fifo;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DEPTH = 4;
   localparam int          WORDS = 4;

   localparam logic [5:0] R_STATUS  = 6'h20;
   localparam logic [5:0] R_CTRL    = 6'h24;
   localparam logic [5:0] R_POP     = 6'h28;
   localparam logic [5:0] R_THRESH  = 6'h2C;
   localparam logic [5:0] R_DROPCNT = 6'h30;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] spi_rx_data;
   logic         spi_rx_valid;
   logic         irq_rx;
   logic [2:0]   fifo_level;

   aes_rx_block_fifo_if bus ();

   aes_rx_block_fifo #(
      .BASE_ADDR  (BASE),
      .BLOCK_BITS (128),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .spi_rx_data  (spi_rx_data),
      .spi_rx_valid (spi_rx_valid),
      .irq_rx       (irq_rx),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [127:0] mq[$];
   bit           m_ovf;
   int           m_drop;
   bit           m_irq_en;
   int           m_thresh;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int eff_thresh();
      if (m_thresh == 0) return 1;
      if (m_thresh > DEPTH) return DEPTH;
      return m_thresh;
   endfunction

   function automatic bit m_irq();
      return m_irq_en && (mq.size() >= eff_thresh());
   endfunction

   function automatic logic [31:0] m_status();
      int s;
      s = mq.size();
      return (32'(s) << 16) | (32'(m_ovf) << 2) | (32'(s == DEPTH) << 1) | 32'(s != 0);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_drop = 0; m_irq_en = 0; m_thresh = 1;
   endtask

   task automatic model_step(input bit push, input logic [127:0] d, input bit pop,
                             input bit flush);
      if (flush) begin
         mq.delete();
      end else begin
         if (pop && mq.size() > 0) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else begin
               m_ovf = 1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
   endtask

   task automatic model_write(input logic [5:0] off, input logic [31:0] d, input bit push,
                              input logic [127:0] blk);
      bit pop, flush;
      pop = 0; flush = 0;
      if (off == R_CTRL) begin
         m_irq_en = d[0];
         if (d[2]) begin m_ovf = 0; m_drop = 0; end
         flush = d[1];
      end else if (off == R_POP) begin
         pop = 1;
      end else if (off == R_THRESH) begin
         m_thresh = int'(d[6:0]);
      end
      model_step(push, blk, pop, flush);
   endtask

   // Called at posedge+1; returns in the ready cycle
   task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rdata);
      int n;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.mem_ready && n < 8);
      check("ready_latency", 32'(n), 32'd1);
      rdata = bus.mem_rdata;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
   endtask

   task automatic read_reg(input logic [5:0] off, output logic [31:0] d);
      bus_access(BASE + 32'(off), 32'h0, 4'h0, d);
      @(posedge clk); #1;
   endtask

   // Optionally pulses spi_rx_valid during the ready cycle of the write
   task automatic write_reg(input logic [5:0] off, input logic [31:0] d, input bit push,
                            input logic [127:0] blk);
      logic [31:0] unused_rd;
      bus_access(BASE + 32'(off), d, 4'hF, unused_rd);
      if (push) begin
         spi_rx_valid = 1'b1;
         spi_rx_data  = blk;
      end
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      model_write(off, d, push, blk);
   endtask

   task automatic push_block(input logic [127:0] blk);
      spi_rx_valid = 1'b1;
      spi_rx_data  = blk;
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      model_step(1, blk, 0, 0);
   endtask

   task automatic check_ports();
      check("fifo_level", 32'(fifo_level), 32'(mq.size()));
      check("irq_rx", 32'(irq_rx), 32'(m_irq()));
   endtask

   task automatic check_all();
      logic [31:0] rd;
      logic [127:0] head;
      check_ports();
      read_reg(R_STATUS, rd);
      check("status", rd, m_status());
      head = (mq.size() > 0) ? mq[0] : 128'h0;
      for (int k = 0; k < WORDS; k++) begin
         read_reg(6'(4 * k), rd);
         check("data_word", rd, head[32*k +: 32]);
      end
      read_reg(R_DROPCNT, rd);
      check("dropcnt", rd, 32'(m_drop));
   endtask

   function automatic logic [127:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [31:0]  rd;
      logic [127:0] blk;
      logic [127:0] b0;
      logic [127:0] tail;
      int           op;

      reset = 1'b1;
      bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
      spi_rx_valid = 1'b0; spi_rx_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.mem_ready), 32'd0);
      check("rst_rdata", bus.mem_rdata, 32'd0);
      check("rst_irq", 32'(irq_rx), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      read_reg(R_THRESH, rd);
      check("rst_thresh", rd, 32'd1);
      check_all();

      // 1: three blocks, word order and pop
      b0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      push_block(b0);
      push_block(128'h10203040_50607080_90A0B0C0_D0E0F000);
      push_block(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
      read_reg(R_STATUS, rd);
      check("t1_status", rd, 32'h0003_0001);
      read_reg(6'h00, rd); check("t1_data0", rd, 32'hCCDDEEFF);
      read_reg(6'h04, rd); check("t1_data1", rd, 32'h8899AABB);
      read_reg(6'h08, rd); check("t1_data2", rd, 32'h44556677);
      read_reg(6'h0C, rd); check("t1_data3", rd, 32'h00112233);
      write_reg(R_POP, 32'h0, 0, '0);
      read_reg(6'h00, rd); check("t1_pop_data0", rd, 32'hD0E0F000);
      check_all();

      // 2: overflow into a depth-4 queue, then clear
      write_reg(R_CTRL, 32'h2, 0, '0);
      for (int i = 0; i < 6; i++) push_block(rand_block());
      read_reg(R_STATUS, rd);
      check("t2_status", rd, 32'h0004_0007);
      read_reg(R_DROPCNT, rd);
      check("t2_dropcnt", rd, 32'd2);
      write_reg(R_CTRL, 32'h4, 0, '0);
      read_reg(R_STATUS, rd);
      check("t2_clr_status", rd, 32'h0004_0003);
      read_reg(R_DROPCNT, rd);
      check("t2_clr_dropcnt", rd, 32'd0);

      // 3: threshold interrupt
      write_reg(R_CTRL, 32'h2, 0, '0);
      write_reg(R_THRESH, 32'h2, 0, '0);
      write_reg(R_CTRL, 32'h1, 0, '0);
      push_block(rand_block());
      check("t3_irq_one", 32'(irq_rx), 32'd0);
      push_block(rand_block());
      check("t3_irq_two", 32'(irq_rx), 32'd1);
      write_reg(R_POP, 32'h0, 0, '0);
      check("t3_irq_pop", 32'(irq_rx), 32'd0);
      read_reg(R_CTRL, rd);
      check("t3_ctrl", rd, 32'd1);

      // 4: push coincident with pop on a full queue
      for (int i = 0; i < 3; i++) push_block(rand_block());
      check("t4_full_level", 32'(fifo_level), 32'd4);
      tail = rand_block();
      write_reg(R_POP, 32'h0, 1, tail);
      read_reg(R_STATUS, rd);
      check("t4_status", rd, 32'h0004_0003);
      for (int i = 0; i < 3; i++) write_reg(R_POP, 32'h0, 0, '0);
      read_reg(6'h00, rd);
      check("t4_tail_data0", rd, tail[31:0]);
      check_all();

      // 5: flush coincident with push at level 2
      push_block(rand_block());
      check("t5_level2", 32'(fifo_level), 32'd2);
      write_reg(R_CTRL, 32'h3, 1, rand_block());
      read_reg(R_STATUS, rd);
      check("t5_status", rd, 32'h0);
      read_reg(R_DROPCNT, rd);
      check("t5_dropcnt", rd, 32'd0);
      read_reg(6'h00, rd);
      check("t5_data0", rd, 32'd0);
      check_all();

      // Threshold saturation above depth
      write_reg(R_THRESH, 32'h9, 0, '0);
      read_reg(R_THRESH, rd);
      check("thresh_raw", rd, 32'h9);
      for (int i = 0; i < 3; i++) push_block(rand_block());
      check("thresh_sat_3", 32'(irq_rx), 32'd0);
      push_block(rand_block());
      check("thresh_sat_4", 32'(irq_rx), 32'd1);

      // Random phase
      for (int it = 0; it < 160; it++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2, 3: push_block(rand_block());
            4, 5:       write_reg(R_POP, $urandom, 0, '0);
            6:          write_reg(R_POP, $urandom, 1, rand_block());
            7:          write_reg(R_CTRL, 32'h2 | 32'($urandom_range(0, 1)),
                                  bit'($urandom_range(0, 1)), rand_block());
            8:          write_reg(R_CTRL, 32'h4 | 32'($urandom_range(0, 1)), 0, '0);
            default:    write_reg(R_THRESH, 32'($urandom_range(0, 9)), 0, '0);
         endcase
         check_ports();
         if (it % 8 == 7) check_all();
      end

      // 6: reset mid-read with level 3
      write_reg(R_CTRL, 32'h3, 0, '0);
      write_reg(R_THRESH, 32'h1, 0, '0);
      for (int i = 0; i < 3; i++) push_block(rand_block());
      check("t6_pre_irq", 32'(irq_rx), 32'd1);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = BASE + 32'(R_STATUS);
      bus.mem_wstrb = 4'h0;
      #2 reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("t6_ready", 32'(bus.mem_ready), 32'd0);
         check("t6_rdata", bus.mem_rdata, 32'd0);
         check("t6_irq", 32'(irq_rx), 32'd0);
         check("t6_level", 32'(fifo_level), 32'd0);
      end
      bus.mem_valid = 1'b0;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_all();
      bus_access(BASE + 32'h3C, 32'h0, 4'h0, rd);
      check("unmapped_rdata", rd, 32'd0);
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(bus.mem_ready), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
